// File: rtl/fixed_float_converter_if.sv
// Operand/result bundle for the fixed-to-float converter.
// The master side drives operands and the load strobe; the slave side returns the result.
interface fixed_float_converter_if;
  logic [31:0] fixed;
  logic [7:0]  exp_in;
  logic        load_new;
  logic [31:0] float;
  logic        done;

  modport master (output fixed, exp_in, load_new, input float, done);
  modport slave  (input fixed, exp_in, load_new, output float, done);
endinterface

// File: rtl/fixed_float_converter.sv
// Serial fixed-point (mantissa * 2^exp_in) to IEEE-754 single converter.
// Normalises one bit per clock, then rounds to nearest-even and packs.
//
// state | meaning
// IDLE  | waiting for load_new; float holds the last result
// NORM  | shifting mag left until bit 31 is set, decrementing e
// PACK  | round, range-check, register float and pulse done
module fixed_float_converter (
  input  logic                          clk,
  input  logic                          reset,
  fixed_float_converter_if.slave        cv
);

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  state_t             state_q, state_d;
  logic [31:0]        mag_q, mag_d;
  logic signed [9:0]  e_q, e_d;
  logic               sign_q, sign_d;
  logic [31:0]        float_q, float_d;
  logic               done_q, done_d;

  logic [31:0]        load_mag;
  logic signed [9:0]  load_e;
  logic               round_up;
  logic [23:0]        frac_sum;
  logic signed [9:0]  e_rnd;
  logic [31:0]        packed_w;

  // -2^31 negates to itself, which is exactly the unsigned magnitude we want
  assign load_mag = cv.fixed[31] ? (~cv.fixed + 32'd1) : cv.fixed;
  assign load_e   = 10'sd158 + $signed({{2{cv.exp_in[7]}}, cv.exp_in});

  always_comb begin
    round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    frac_sum = {1'b0, mag_q[30:8]} + {23'd0, round_up};
    e_rnd    = e_q + $signed({9'd0, frac_sum[23]});
    if (mag_q == 32'd0) begin
      packed_w = 32'h0000_0000;
    end else if (e_rnd >= 10'sd255) begin
      packed_w = {sign_q, 8'hFF, 23'h0};
    end else if (e_rnd <= 10'sd0) begin
      packed_w = {sign_q, 31'h0};
    end else begin
      packed_w = {sign_q, e_rnd[7:0], frac_sum[22:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    e_d     = e_q;
    sign_d  = sign_q;
    float_d = float_q;
    done_d  = 1'b0;
    // A load in any state restarts; an in-flight job is dropped silently
    if (cv.load_new) begin
      sign_d  = cv.fixed[31];
      mag_d   = load_mag;
      e_d     = load_e;
      state_d = (load_mag == 32'd0) ? PACK : NORM;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        NORM: begin
          if (!mag_q[31]) begin
            mag_d = mag_q << 1;
            e_d   = e_q - 10'sd1;
          end else begin
            state_d = PACK;
          end
        end
        PACK: begin
          float_d = packed_w;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= 32'd0;
      e_q     <= 10'sd0;
      sign_q  <= 1'b0;
      float_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      float_q <= float_d;
      done_q  <= done_d;
    end
  end

  assign cv.float = float_q;
  assign cv.done  = done_q;

endmodule

// File: tb/tb_fixed_float_converter.sv
// Self-checking bench for fixed_float_converter: vector table plus restart/reset sequences.
module tb_fixed_float_converter;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  fixed_float_converter_if cv ();

  fixed_float_converter dut (
    .clk   (clk),
    .reset (reset),
    .cv    (cv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] fixed;
    logic [7:0]  exp_in;
    logic [31:0] expf;
    int          lat;
    bit          exact;
  } vec_t;

  typedef struct {
    logic [31:0] expf;
    int          load_cyc;
    int          lat;
    bit          exact;
  } sb_t;

  vec_t vecs[16];
  sb_t  sb[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic on_done();
    sb_t e;
    int  lat;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
    end else begin
      e   = sb.pop_front();
      lat = cyc - e.load_cyc;
      chk("float", cv.float, e.expf);
      if (e.exact) begin
        chk("latency", lat, e.lat);
      end else begin
        n_cmp++;
        if (lat < 1 || lat > e.lat) begin
          n_bad++;
          $display("FAIL latency_bound: got %0d expected <= %0d", lat, e.lat);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cv.done) on_done();
  endtask

  task automatic start(input logic [31:0] f, input logic [7:0] x, input logic [31:0] expf,
                       input int lat, input bit exact, input bit push);
    sb_t e;
    cv.fixed    = f;
    cv.exp_in   = x;
    cv.load_new = 1'b1;
    if (push) begin
      e.expf = expf; e.load_cyc = cyc + 1; e.lat = lat; e.exact = exact;
      sb.push_back(e);
    end
    tick();
    cv.load_new = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    sb_t e;
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{32'h0000_0001, 8'h00, 32'h3F80_0000, 33, 1'b1};
    vecs[1]  = '{32'hFFFF_FFFA, 8'hFF, 32'hC040_0000, 31, 1'b1};
    vecs[2]  = '{32'h0000_0000, 8'h05, 32'h0000_0000,  2, 1'b0};
    vecs[3]  = '{32'h7FFF_FFFF, 8'h00, 32'h4F00_0000,  3, 1'b1};
    vecs[4]  = '{32'h0000_0001, 8'h7F, 32'h7F00_0000, 33, 1'b1};
    vecs[5]  = '{32'h4000_0000, 8'h7F, 32'h7F80_0000,  3, 1'b1};
    vecs[6]  = '{32'h0000_0001, 8'h80, 32'h0000_0000, 33, 1'b1};
    vecs[7]  = '{32'h8000_0000, 8'h00, 32'hCF00_0000,  2, 1'b1};
    vecs[8]  = '{32'hC000_0000, 8'h00, 32'hCE80_0000,  3, 1'b1};
    vecs[9]  = '{32'h4000_0040, 8'h00, 32'h4E80_0000,  3, 1'b1};
    vecs[10] = '{32'h4000_00C0, 8'h00, 32'h4E80_0002,  3, 1'b1};
    vecs[11] = '{32'h4000_0041, 8'h00, 32'h4E80_0001,  3, 1'b1};
    vecs[12] = '{32'h0000_0001, 8'h82, 32'h0080_0000, 33, 1'b1};
    vecs[13] = '{32'h0000_0001, 8'h81, 32'h0000_0000, 33, 1'b1};
    vecs[14] = '{32'h7FFF_FFFF, 8'h60, 32'h7F00_0000,  3, 1'b1};
    vecs[15] = '{32'h8000_0001, 8'h61, 32'hFF80_0000,  3, 1'b1};

    reset       = 1'b1;
    cv.fixed    = 32'd0;
    cv.exp_in   = 8'd0;
    cv.load_new = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_float", cv.float, 32'h0);
    chk("reset_done", {31'd0, cv.done}, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      start(vecs[i].fixed, vecs[i].exp_in, vecs[i].expf, vecs[i].lat, vecs[i].exact, 1'b1);
      drain(60);
      tick();
    end

    // float must hold the previous result while a new job normalises
    start(32'h0000_0003, 8'h00, 32'h4040_0000, 32, 1'b1, 1'b1);
    tick();
    chk("hold_float", cv.float, 32'hFF80_0000);
    drain(60);
    tick();

    // restart mid-NORM: only the second job reports
    start(32'h0000_0001, 8'h00, 32'h0, 0, 1'b1, 1'b0);
    repeat (5) tick();
    start(32'h0000_0002, 8'h00, 32'h4000_0000, 32, 1'b1, 1'b1);
    drain(60);
    repeat (3) tick();

    // restart while in PACK
    start(32'h8000_0000, 8'h00, 32'h0, 0, 1'b1, 1'b0);
    start(32'h0000_0003, 8'h00, 32'h4040_0000, 32, 1'b1, 1'b1);
    drain(60);
    repeat (3) tick();

    // load_new held high: one result, timed from the last load edge
    cv.fixed    = 32'h8000_0000;
    cv.exp_in   = 8'h01;
    cv.load_new = 1'b1;
    repeat (3) tick();
    e.expf = 32'hCF80_0000; e.load_cyc = cyc + 1; e.lat = 2; e.exact = 1'b1;
    sb.push_back(e);
    tick();
    cv.load_new = 1'b0;
    drain(60);
    repeat (3) tick();

    // reset mid-conversion: float cleared, no done afterwards
    start(32'h0000_0001, 8'h00, 32'h0, 0, 1'b1, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midreset_float", cv.float, 32'h0);
    chk("midreset_done", {31'd0, cv.done}, 32'h0);
    reset = 1'b0;
    repeat (40) tick();
    chk("idle_float", cv.float, 32'h0);

    start(32'h0000_0002, 8'h00, 32'h4000_0000, 32, 1'b1, 1'b1);
    drain(60);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
